// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 512Kx8 asynchronous SRAM. Port A has priority,
// and a starvation counter forces a port B grant after STARVE_LIMIT A grants in a row.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [18:0] a_addr_i,
  input  logic [7:0]  a_data_i,
  output logic [7:0]  a_data_o,
  output logic        a_ack_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [18:0] b_addr_i,
  input  logic [7:0]  b_data_i,
  output logic [7:0]  b_data_o,
  output logic        b_ack_o,
  output logic [18:0] sram_addr_o,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe_o,
  input  logic [7:0]  sram_data_i,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        grant_b_q, grant_b_d;
  logic        we_q, we_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  starve_q, starve_d;
  logic [18:0] sram_addr_q, sram_addr_d;
  logic [7:0]  sram_data_q, sram_data_d;
  logic        data_oe_q, data_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [7:0]  a_data_q, a_data_d;
  logic [7:0]  b_data_q, b_data_d;
  logic        pick_b;
  logic        sel_we;

  always_comb begin
    state_d     = state_q;
    grant_b_d   = grant_b_q;
    we_d        = we_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    data_oe_d   = data_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    pick_b      = b_req_i && (!a_req_i || (starve_q == STARVE_MAX));
    sel_we      = pick_b ? b_we_i : a_we_i;

    case (state_q)
      IDLE: begin
        if (a_req_i || b_req_i) begin
          // Starvation only counts A wins that happened while B was waiting.
          if (pick_b) begin
            starve_d = 4'd0;
          end else if (b_req_i) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
          grant_b_d   = pick_b;
          we_d        = sel_we;
          sram_addr_d = pick_b ? b_addr_i : a_addr_i;
          sram_data_d = pick_b ? b_data_i : a_data_i;
          ce_n_d      = 1'b0;
          oe_n_d      = sel_we;
          data_oe_d   = sel_we;
          we_n_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        we_n_d  = ~we_q;
        wait_d  = WAIT_INIT;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          we_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          ce_n_d    = 1'b1;
          data_oe_d = 1'b0;
          if (grant_b_q) begin
            b_ack_d = 1'b1;
            if (!we_q) b_data_d = sram_data_i;
          end else begin
            a_ack_d = 1'b1;
            if (!we_q) a_data_d = sram_data_i;
          end
          state_d = DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      grant_b_q   <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= 4'd0;
      starve_q    <= 4'd0;
      sram_addr_q <= 19'd0;
      sram_data_q <= 8'd0;
      data_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_data_q    <= 8'd0;
      b_data_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_b_q   <= grant_b_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      data_oe_q   <= data_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
    end
  end

  assign a_data_o       = a_data_q;
  assign a_ack_o        = a_ack_q;
  assign b_data_o       = b_data_q;
  assign b_ack_o        = b_ack_q;
  assign sram_addr_o    = sram_addr_q;
  assign sram_data_o    = sram_data_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: an SRAM device model, a timeline model of each
// access window, and directed tests on a WAIT_STATES=1 and a WAIT_STATES=0 instance.
module tb_sram_arbiter;
  localparam int WS = 1;
  localparam int SL = 4;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [18:0] a_addr = 0, b_addr = 0;
  logic [7:0]  a_wdata = 0, b_wdata = 0;
  logic [7:0]  a_rdata, b_rdata, s_wdata, s_din;
  logic        a_ack, b_ack, s_doe, s_ce_n, s_oe_n, s_we_n, busy;
  logic [18:0] s_addr;

  logic        a0_req = 0, a0_we = 0, b0_req = 0, b0_we = 0;
  logic [18:0] a0_addr = 0, b0_addr = 0;
  logic [7:0]  a0_wdata = 0, b0_wdata = 0;
  logic [7:0]  a0_rdata, b0_rdata, s0_wdata, s0_din;
  logic        a0_ack, b0_ack, s0_doe, s0_ce_n, s0_oe_n, s0_we_n, busy0;
  logic [18:0] s0_addr;

  sram_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
    .a_data_o(a_rdata), .a_ack_o(a_ack),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_data_i(b_wdata),
    .b_data_o(b_rdata), .b_ack_o(b_ack),
    .sram_addr_o(s_addr), .sram_data_o(s_wdata), .sram_data_oe_o(s_doe),
    .sram_data_i(s_din), .sram_ce_n_o(s_ce_n), .sram_oe_n_o(s_oe_n),
    .sram_we_n_o(s_we_n), .busy_o(busy)
  );

  sram_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(SL)) dut0 (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .a_req_i(a0_req), .a_we_i(a0_we), .a_addr_i(a0_addr), .a_data_i(a0_wdata),
    .a_data_o(a0_rdata), .a_ack_o(a0_ack),
    .b_req_i(b0_req), .b_we_i(b0_we), .b_addr_i(b0_addr), .b_data_i(b0_wdata),
    .b_data_o(b0_rdata), .b_ack_o(b0_ack),
    .sram_addr_o(s0_addr), .sram_data_o(s0_wdata), .sram_data_oe_o(s0_doe),
    .sram_data_i(s0_din), .sram_ce_n_o(s0_ce_n), .sram_oe_n_o(s0_oe_n),
    .sram_we_n_o(s0_we_n), .busy_o(busy0)
  );

  // Physical SRAM contents and the model's idea of what they should hold.
  logic [7:0] sram_mem [0:524287];
  logic [7:0] ref_mem  [0:524287];

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h96;
  endfunction

  // The SRAM only drives its bus while selected and output-enabled; 0xEE marks a floating bus.
  assign s_din  = (!s_ce_n && !s_oe_n) ? sram_mem[s_addr] : 8'hEE;
  assign s0_din = (!s0_ce_n && !s0_oe_n) ? sram_mem[s0_addr] : 8'hEE;

  always @(posedge clk_i) begin
    if (!s_ce_n && !s_we_n && s_doe) sram_mem[s_addr] <= s_wdata;
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each grant owns a fixed window of clock edges.
  int          ecount = 0;
  logic        m_act = 1'b0;
  logic        m_b = 1'b0;
  logic        m_we = 1'b0;
  logic [18:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  int          m_start = 0;
  int          m_ack_edge = 0;
  int          m_free = 0;
  int          m_starve = 0;
  logic [7:0]  exp_a_data = 8'h00;
  logic [7:0]  exp_b_data = 8'h00;

  always @(posedge clk_i or negedge reset_n_i) begin : model
    int e;
    bit take_b;
    if (!reset_n_i) begin
      m_act      <= 1'b0;
      m_free     <= 0;
      m_starve   <= 0;
      exp_a_data <= 8'h00;
      exp_b_data <= 8'h00;
    end else begin
      e = ecount + 1;
      ecount <= e;
      if (m_act && e == m_ack_edge) begin
        if (m_we) ref_mem[m_addr] <= m_data;
        else if (m_b) exp_b_data <= ref_mem[m_addr];
        else exp_a_data <= ref_mem[m_addr];
      end
      if (e >= m_free && (a_req || b_req)) begin
        take_b     = b_req && (!a_req || m_starve == SL);
        m_act      <= 1'b1;
        m_b        <= take_b;
        m_we       <= take_b ? b_we : a_we;
        m_addr     <= take_b ? b_addr : a_addr;
        m_data     <= take_b ? b_wdata : a_wdata;
        m_start    <= e;
        m_ack_edge <= e + WS + 2;
        m_free     <= e + WS + 4;
        m_starve   <= take_b ? 0 : (b_req ? m_starve + 1 : 0);
      end
    end
  end

  always @(negedge clk_i) begin : compare
    int e;
    bit win, sa, dn;
    e   = ecount;
    win = m_act && e >= m_start && e <= m_ack_edge;
    sa  = m_act && e >= m_start && e < m_ack_edge;
    dn  = m_act && e == m_ack_edge;
    checkOutput("busy", busy, win);
    checkOutput("a_ack", a_ack, dn && !m_b);
    checkOutput("b_ack", b_ack, dn && m_b);
    checkOutput("ce_n", s_ce_n, !sa);
    checkOutput("oe_n", s_oe_n, !(sa && !m_we));
    checkOutput("we_n", s_we_n, !(sa && m_we && e > m_start));
    checkOutput("data_oe", s_doe, sa && m_we);
    if (sa || dn) checkOutput("sram_addr", s_addr, m_addr);
    if ((sa || dn) && m_we) checkOutput("sram_wdata", s_wdata, m_data);
    checkOutput("a_data", a_rdata, exp_a_data);
    checkOutput("b_data", b_rdata, exp_b_data);
    checkOutput("oe_we_exclusive", !s_oe_n && !s_we_n, 0);
    checkOutput("single_ack", a_ack && b_ack, 0);
    if (!reset_n_i) begin
      checkOutput("reset_addr", s_addr, 0);
      checkOutput("reset_wdata", s_wdata, 0);
    end
  end

  int we_lo_cnt = 0, oe_lo_cnt = 0, doe_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;
  always @(negedge clk_i) begin
    if (!s_we_n) we_lo_cnt <= we_lo_cnt + 1;
    if (!s_oe_n) oe_lo_cnt <= oe_lo_cnt + 1;
    if (s_doe)   doe_cnt   <= doe_cnt + 1;
    if (a_ack)   a_ack_cnt <= a_ack_cnt + 1;
    if (b_ack)   b_ack_cnt <= b_ack_cnt + 1;
  end

  task automatic clearCounters();
    we_lo_cnt <= 0; oe_lo_cnt <= 0; doe_cnt <= 0; a_ack_cnt <= 0; b_ack_cnt <= 0;
  endtask

  // port 0 = A, 1 = B, 2 = A of the zero-wait-state instance; called at a negedge.
  task automatic applyStimulus(input int port, input logic we, input logic [18:0] addr,
                               input logic [7:0] wdata, input bit keep,
                               output logic [7:0] rdata, output int lat);
    bit done = 1'b0;
    lat = 0;
    case (port)
      0: begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
      1: begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
      default: begin a0_we = we; a0_addr = addr; a0_wdata = wdata; a0_req = 1'b1; end
    endcase
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk_i);
      lat++;
      case (port)
        0: done = a_ack;
        1: done = b_ack;
        default: done = a0_ack;
      endcase
    end
    checkOutput($sformatf("ack_timeout_port%0d", port), done, 1);
    case (port)
      0: begin rdata = a_rdata; if (!keep) a_req = 1'b0; end
      1: begin rdata = b_rdata; if (!keep) b_req = 1'b0; end
      default: begin rdata = a0_rdata; if (!keep) a0_req = 1'b0; end
    endcase
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    logic [7:0] rd;
    int lat;
    bit found;
    bit got;
    bit [9:0] seq;
    bit [9:0] t3_exp;

    for (int i = 0; i < 524288; i++) begin
      sram_mem[i] = pat(19'(i));
      ref_mem[i]  = pat(19'(i));
    end
    sram_mem[19'h12345] = 8'h5A;
    ref_mem[19'h12345]  = 8'h5A;

    repeat (3) @(negedge clk_i);
    $display("[TB] reset state");
    checkOutput("rst_ce_n", s_ce_n, 1);
    checkOutput("rst_oe_n", s_oe_n, 1);
    checkOutput("rst_we_n", s_we_n, 1);
    checkOutput("rst_data_oe", s_doe, 0);
    checkOutput("rst_acks", {a_ack, b_ack}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_a_data", a_rdata, 8'h00);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] single A read");
    clearCounters();
    applyStimulus(0, 1'b0, 19'h12345, 8'h00, 1'b0, rd, lat);
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_data", rd, 8'h5A);
    repeat (3) @(negedge clk_i);
    checkOutput("t1_oe_low_cycles", oe_lo_cnt, 3);
    checkOutput("t1_a_ack_count", a_ack_cnt, 1);

    $display("[TB] single B write");
    clearCounters();
    applyStimulus(1, 1'b1, 19'h00200, 8'hC3, 1'b0, rd, lat);
    checkOutput("t2_latency", lat, 4);
    repeat (3) @(negedge clk_i);
    checkOutput("t2_we_low_cycles", we_lo_cnt, 2);
    checkOutput("t2_data_oe_cycles", doe_cnt, 3);
    checkOutput("t2_oe_low_cycles", oe_lo_cnt, 0);
    checkOutput("t2_b_ack_count", b_ack_cnt, 1);
    checkOutput("t2_a_ack_count", a_ack_cnt, 0);
    checkOutput("t2_sram_mem", sram_mem[19'h00200], 8'hC3);

    $display("[TB] both ports saturating");
    t3_exp = 10'b1000010000;
    seq = '0;
    a_we = 1'b0; a_addr = 19'h00010; b_we = 1'b0; b_addr = 19'h00020;
    a_req = 1'b1; b_req = 1'b1;
    for (int n = 0; n < 10; n++) begin
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk_i);
        if (a_ack || b_ack) begin
          got = 1'b1;
          seq[n] = b_ack;
        end
      end
      checkOutput("t3_ack_timeout", got, 1);
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int n = 0; n < 10; n++) checkOutput($sformatf("t3_grant%0d", n), seq[n], t3_exp[n]);
    checkOutput("t3_a_data", a_rdata, 8'h86);
    checkOutput("t3_b_data", b_rdata, 8'hB6);
    repeat (2) @(negedge clk_i);

    $display("[TB] B sector stream with an A read");
    fork
      begin : b_stream
        logic [7:0] brd;
        int blat;
        for (int i = 0; i < 512; i++) begin
          applyStimulus(1, 1'b0, 19'h04000 + 19'(i), 8'h00, (i != 511), brd, blat);
          checkOutput($sformatf("t4_b_byte%0d", i), brd, pat(19'h04000 + 19'(i)));
        end
      end
      begin : a_single
        logic [7:0] ard;
        int alat;
        repeat (40) @(negedge clk_i);
        applyStimulus(0, 1'b0, 19'h0ABCD, 8'h00, 1'b0, ard, alat);
        checkOutput("t4_a_data", ard, 8'hF0);
        checkOutput("t4_a_served_next_idle", alat <= 8, 1);
      end
    join
    repeat (2) @(negedge clk_i);

    $display("[TB] reset during A write");
    clearCounters();
    a_we = 1'b1; a_addr = 19'h00300; a_wdata = 8'h77; a_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (!s_we_n) found = 1'b1;
    end
    checkOutput("t5_we_seen", found, 1);
    #1 reset_n_i = 1'b0;
    a_req = 1'b0;
    #1;
    checkOutput("t5_we_n_async", s_we_n, 1);
    checkOutput("t5_ce_n_async", s_ce_n, 1);
    checkOutput("t5_data_oe_async", s_doe, 0);
    checkOutput("t5_busy_async", busy, 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("t5_busy_after", busy, 0);
    checkOutput("t5_no_ack", a_ack_cnt, 0);
    applyStimulus(0, 1'b0, 19'h12345, 8'h00, 1'b0, rd, lat);
    checkOutput("t5_read_after_latency", lat, 4);
    checkOutput("t5_read_after_data", rd, 8'h5A);

    $display("[TB] zero wait states back to back");
    applyStimulus(2, 1'b0, 19'h00000, 8'h00, 1'b1, rd, lat);
    checkOutput("t6_first_latency", lat, 3);
    checkOutput("t6_first_data", rd, 8'h96);
    applyStimulus(2, 1'b0, 19'h00001, 8'h00, 1'b0, rd, lat);
    checkOutput("t6_ack_spacing", lat, 4);
    checkOutput("t6_second_data", rd, 8'h97);
    repeat (3) @(negedge clk_i);
    checkOutput("t6_busy_after", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
